// File: rtl/sign_negator.sv
// Registered two's-complement negator with pass-through bypass; 1-cycle latency, no backpressure.
// Define SIGN_NEGATOR_SAT_EN to saturate -MIN_INT to MAX_INT instead of wrapping; ovf flags it in both builds.
module sign_negator #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             neg_en,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_INT = ~MIN_INT;
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             is_min;
  logic [WIDTH-1:0] negated;
  logic [WIDTH-1:0] result;
  logic             result_ovf;

  always_comb begin
    is_min     = (in == MIN_INT);
    negated    = (~in) + ONE;
    result     = in;
    result_ovf = 1'b0;
    if (neg_en) begin
      result_ovf = is_min;
`ifdef SIGN_NEGATOR_SAT_EN
      result     = is_min ? MAX_INT : negated;
`else
      // Wrapping leaves MIN_INT unchanged, which is exactly what ~in+1 yields.
      result     = negated;
`endif
    end
  end

  // out/ovf hold across idle cycles; only the valid strobe drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= result;
        ovf <= result_ovf;
      end
    end
  end

endmodule

// File: tb/tb_sign_negator.sv
// Directed self-checking bench for sign_negator at WIDTH=16.
module tb_sign_negator;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        neg_en;
  logic [15:0] in;
  logic [15:0] out;
  logic        out_valid;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  sign_negator #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .neg_en(neg_en),
    .in(in), .out(out), .out_valid(out_valid), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SIGN_NEGATOR_SAT_EN
  localparam logic [15:0] MIN_NEG = 16'h7FFF;
`else
  localparam logic [15:0] MIN_NEG = 16'h8000;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one word at the falling edge, then sample #1 after the accepting edge.
  task automatic step(input logic v, input logic n, input logic [15:0] d);
    @(negedge clk);
    in_valid = v;
    neg_en   = n;
    in       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [15:0] eo, input logic ev, input logic eovf);
    check({tag, "_out"}, {16'h0, out}, {16'h0, eo});
    check({tag, "_vld"}, {31'h0, out_valid}, {31'h0, ev});
    check({tag, "_ovf"}, {31'h0, ovf}, {31'h0, eovf});
  endtask

  logic [15:0] words [9];
  logic [15:0] w;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    neg_en   = 1'b0;
    in       = 16'h0;
    #23;
    expect_out("reset", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b1, 1'b1, 16'd5);
    expect_out("neg5", 16'hFFFB, 1'b1, 1'b0);
    step(1'b1, 1'b1, 16'hFB2E);             // -1234
    expect_out("neg_m1234", 16'd1234, 1'b1, 1'b0);
    step(1'b1, 1'b1, 16'h8000);
    expect_out("min_int", MIN_NEG, 1'b1, 1'b1);
    step(1'b1, 1'b0, 16'h8000);
    expect_out("bypass_min", 16'h8000, 1'b1, 1'b0);
    step(1'b1, 1'b1, 16'h7FFF);
    expect_out("max_int", 16'h8001, 1'b1, 1'b0);
    step(1'b1, 1'b1, 16'hFFFF);
    expect_out("neg_m1", 16'h0001, 1'b1, 1'b0);
    step(1'b1, 1'b1, 16'h0000);
    expect_out("zero", 16'h0000, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'h1234);
    expect_out("bypass", 16'h1234, 1'b1, 1'b0);

    // Idle cycle with MIN_INT/neg_en on the bus must not disturb held outputs.
    step(1'b0, 1'b1, 16'h8000);
    expect_out("idle_hold", 16'h1234, 1'b0, 1'b0);

    for (int i = 0; i < 9; i++) begin
      w = 16'($urandom_range(16'hFFFF, 0));
      if (w == 16'h8000) w = 16'h8001;
      words[i] = w;
    end
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, words[i]);
      expect_out($sformatf("stream%0d", i), 16'(17'h10000 - {1'b0, words[i]}), 1'b1, 1'b0);
    end
    step(1'b0, 1'b0, 16'h0);
    expect_out("stream_hold", 16'(17'h10000 - {1'b0, words[8]}), 1'b0, 1'b0);

    // Asynchronous reset mid-cycle with a valid MIN_INT result showing.
    step(1'b1, 1'b1, 16'h8000);
    expect_out("pre_rst", MIN_NEG, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    expect_out("post_rst", 16'h0000, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'd1);
    expect_out("first_after_rst", 16'hFFFF, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
